// File: rtl/retire_unit.sv
// ---------------------------------------------------------------------------
// retire_unit
//
// Completion/retire stage behind the reorder buffer. Each cycle up to LANES
// in-order instructions are offered by the ROB head. Non-store lanes turn into
// registered register-file write strobes. Store lanes are pushed into a
// circular store queue, which drains one entry per cycle to data memory over
// a valid/ready handshake. Lanes are accepted as a strict prefix so that
// retirement never goes out of program order.
//
// Instruction lane layout (IW = DATA_W + ADDR_W + 1), lane i at [i*IW +: IW]:
//   bit 0                      store flag
//   non-store: [REG_AW+1:2]    destination register, [1] write enable
//   store:     [IW-1:ADDR_W+1] store data, [ADDR_W:1] store address
//
// Ports:
//   i_clk             clock, all state updates on the rising edge
//   i_rst             synchronous active-high reset
//   i_rob_out_inst    LANES packed instructions
//   i_rob_out_valid   per-lane valid
//   o_rob_out_ready   per-lane accept (combinational, prefix rule)
//   o_update_addr     registered destination per lane
//   o_update_en       registered write strobe per lane
//   o_retired_count   registered number of lanes accepted last cycle
//   o_mem_req_valid   store queue head valid
//   o_mem_req_addr    head address
//   o_mem_req_data    head data
//   i_mem_req_ready   memory takes the head this cycle
//   o_sq_count        occupied store queue entries
//   o_sq_full         queue full
//   o_sq_empty        queue empty
// ---------------------------------------------------------------------------
module retire_unit #(
    parameter int LANES    = 2,
    parameter int SQ_DEPTH = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int REG_AW   = 5
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [LANES*(DATA_W+ADDR_W+1)-1:0]     i_rob_out_inst,
    input  logic [LANES-1:0]                       i_rob_out_valid,
    output logic [LANES-1:0]                       o_rob_out_ready,
    output logic [LANES*REG_AW-1:0]                o_update_addr,
    output logic [LANES-1:0]                       o_update_en,
    output logic [$clog2(LANES+1)-1:0]             o_retired_count,
    output logic                                   o_mem_req_valid,
    output logic [ADDR_W-1:0]                      o_mem_req_addr,
    output logic [DATA_W-1:0]                      o_mem_req_data,
    input  logic                                   i_mem_req_ready,
    output logic [$clog2(SQ_DEPTH+1)-1:0]          o_sq_count,
    output logic                                   o_sq_full,
    output logic                                   o_sq_empty
);

    localparam int IW  = DATA_W + ADDR_W + 1;
    localparam int PW  = $clog2(SQ_DEPTH);
    localparam int CW  = $clog2(SQ_DEPTH + 1);
    localparam int RCW = $clog2(LANES + 1);
    // Store counts and free space share one width with a spare bit so the
    // free-space compare can never wrap.
    localparam int SW  = CW + 1;
    localparam logic [SW-1:0] DEPTH_V = SW'(SQ_DEPTH);

    // Queue state
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_sq_count;
    logic [ADDR_W-1:0] r_sq_addr [SQ_DEPTH];
    logic [DATA_W-1:0] r_sq_data [SQ_DEPTH];

    // Retire outputs
    logic [LANES*REG_AW-1:0] r_update_addr;
    logic [LANES-1:0]        r_update_en;
    logic [RCW-1:0]          r_retired_count;

    // Acceptance / push bookkeeping
    logic [SW-1:0]    w_free;
    logic [LANES-1:0] w_is_store;
    logic [LANES-1:0] w_accept;
    logic [SW-1:0]    w_push_cnt;
    logic [RCW-1:0]   w_ret_cnt;
    logic             w_blocked;
    logic [PW-1:0]    w_wr_idx [LANES];
    logic             w_pop;
    logic             w_empty;

    // Free space is taken from the registered count only; a pop in the same
    // cycle is not credited, which keeps ready independent of mem ready and
    // guarantees a push never lands on the entry being popped.
    assign w_free  = DEPTH_V - {1'b0, r_sq_count};
    assign w_empty = (r_sq_count == '0);
    assign w_pop   = ~w_empty & i_mem_req_ready;

    // Prefix acceptance: once a lane is invalid or would overflow the queue,
    // every higher lane is blocked regardless of its type.
    always_comb begin
        w_accept   = '0;
        w_is_store = '0;
        w_push_cnt = '0;
        w_ret_cnt  = '0;
        w_blocked  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            w_is_store[i] = i_rob_out_inst[i*IW];
            // Slot for this lane: tail plus stores already taken in lower lanes
            w_wr_idx[i]   = r_tail + w_push_cnt[PW-1:0];
            if (!w_blocked && i_rob_out_valid[i] &&
                ((w_push_cnt + SW'(w_is_store[i])) <= w_free)) begin
                w_accept[i] = 1'b1;
                w_push_cnt  = w_push_cnt + SW'(w_is_store[i]);
                w_ret_cnt   = w_ret_cnt + RCW'(1);
            end else begin
                w_blocked = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_sq_count      <= '0;
            r_update_addr   <= '0;
            r_update_en     <= '0;
            r_retired_count <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                // Destination field loads unconditionally; only the strobe
                // is qualified by acceptance and lane type.
                r_update_addr[i*REG_AW +: REG_AW] <= i_rob_out_inst[i*IW+2 +: REG_AW];
                r_update_en[i] <= w_accept[i] & ~w_is_store[i] & i_rob_out_inst[i*IW+1];
            end
            r_retired_count <= w_ret_cnt;
            r_tail          <= r_tail + w_push_cnt[PW-1:0];
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_sq_count <= r_sq_count + w_push_cnt[CW-1:0] - CW'(w_pop);
        end
    end

    // Queue storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_accept[i] && w_is_store[i]) begin
                r_sq_addr[w_wr_idx[i]] <= i_rob_out_inst[i*IW+1 +: ADDR_W];
                r_sq_data[w_wr_idx[i]] <= i_rob_out_inst[i*IW+ADDR_W+1 +: DATA_W];
            end
        end
    end

    assign o_rob_out_ready = w_accept;
    assign o_update_addr   = r_update_addr;
    assign o_update_en     = r_update_en;
    assign o_retired_count = r_retired_count;
    assign o_mem_req_valid = ~w_empty;
    assign o_mem_req_addr  = r_sq_addr[r_head];
    assign o_mem_req_data  = r_sq_data[r_head];
    assign o_sq_count      = r_sq_count;
    assign o_sq_full       = (r_sq_count == CW'(SQ_DEPTH));
    assign o_sq_empty      = w_empty;

endmodule

// File: tb/tb_retire_unit.sv
module tb_retire_unit;

    localparam int LANES  = 2;
    localparam int SQD    = 4;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int RAW    = 5;
    localparam int IW     = DW + AW + 1;

    logic                  clk;
    logic                  rst;
    logic [LANES*IW-1:0]   inst;
    logic [LANES-1:0]      valid;
    logic [LANES-1:0]      ready;
    logic [LANES*RAW-1:0]  upd_addr;
    logic [LANES-1:0]      upd_en;
    logic [1:0]            ret_cnt;
    logic                  mvalid;
    logic [AW-1:0]         maddr;
    logic [DW-1:0]         mdata;
    logic                  mready;
    logic [2:0]            sq_count;
    logic                  sq_full;
    logic                  sq_empty;

    int checks = 0;
    int errors = 0;

    retire_unit #(.LANES(LANES), .SQ_DEPTH(SQD), .DATA_W(DW), .ADDR_W(AW), .REG_AW(RAW)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_rob_out_inst  (inst),
        .i_rob_out_valid (valid),
        .o_rob_out_ready (ready),
        .o_update_addr   (upd_addr),
        .o_update_en     (upd_en),
        .o_retired_count (ret_cnt),
        .o_mem_req_valid (mvalid),
        .o_mem_req_addr  (maddr),
        .o_mem_req_data  (mdata),
        .i_mem_req_ready (mready),
        .o_sq_count      (sq_count),
        .o_sq_full       (sq_full),
        .o_sq_empty      (sq_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IW-1:0] st(input logic [31:0] a, input logic [31:0] d);
        return {d, a, 1'b1};
    endfunction

    function automatic logic [IW-1:0] ns(input logic [4:0] dest, input logic wen);
        return {{(IW-RAW-2){1'b0}}, dest, wen, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [IW-1:0] l1, input logic [IW-1:0] l0, input logic [1:0] v);
        inst  = {l1, l0};
        valid = v;
        #1;
    endtask

    initial begin
        logic [31:0] exp_a;
        int nk;

        rst    = 1'b1;
        inst   = '0;
        valid  = '0;
        mready = 1'b0;
        step();
        step();

        // Reset state
        check("rst_upd_en", upd_en, 2'b00);
        check("rst_upd_addr", upd_addr, 10'd0);
        check("rst_ret_cnt", ret_cnt, 2'd0);
        check("rst_sq_count", sq_count, 3'd0);
        check("rst_sq_empty", sq_empty, 1'b1);
        check("rst_sq_full", sq_full, 1'b0);
        check("rst_mvalid", mvalid, 1'b0);
        rst = 1'b0;

        // Non-store lanes
        drive(ns(5'd7, 1'b0), ns(5'd5, 1'b1), 2'b11);
        check("ns_ready", ready, 2'b11);
        step();
        check("ns_upd_en", upd_en, 2'b01);
        check("ns_upd_addr0", upd_addr[4:0], 5'd5);
        check("ns_upd_addr1", upd_addr[9:5], 5'd7);
        check("ns_ret_cnt", ret_cnt, 2'd2);

        // Fill with mem not ready, then backpressure
        drive(st(32'h204, 32'hA1), st(32'h200, 32'hA0), 2'b11);
        check("fill1_ready", ready, 2'b11);
        step();
        check("fill1_count", sq_count, 3'd2);
        check("fill1_upd_en", upd_en, 2'b00);
        check("fill1_mvalid", mvalid, 1'b1);
        drive(st(32'h20C, 32'hA3), st(32'h208, 32'hA2), 2'b11);
        check("fill2_ready", ready, 2'b11);
        step();
        check("fill2_count", sq_count, 3'd4);
        check("fill2_full", sq_full, 1'b1);
        drive(st(32'h214, 32'hA5), st(32'h210, 32'hA4), 2'b11);
        check("full_ready", ready, 2'b00);
        // Ready must not follow mem ready even when a pop happens this cycle
        mready = 1'b1;
        #1;
        check("full_ready_mrdy", ready, 2'b00);
        check("full_head_addr", maddr, 32'h200);
        check("full_head_data", mdata, 32'hA0);
        step();
        check("full_ret_cnt", ret_cnt, 2'd0);
        check("full_pop_count", sq_count, 3'd3);
        drive('0, '0, 2'b00);
        for (int k = 1; k < 4; k++) begin
            check("fill_drain_addr", maddr, 32'h200 + 32'(4 * k));
            step();
        end
        check("fill_drain_empty", sq_empty, 1'b1);

        // Partial acceptance (head = tail = 0 here)
        mready = 1'b0;
        drive(st(32'h304, 32'hB1), st(32'h300, 32'hB0), 2'b11);
        step();
        drive('0, st(32'h308, 32'hB2), 2'b01);
        step();
        check("part_count3", sq_count, 3'd3);
        drive(st(32'h310, 32'hB4), st(32'h30C, 32'hB3), 2'b11);
        check("part_ready_ss", ready, 2'b01);
        step();
        check("part_count4", sq_count, 3'd4);
        check("part_ret_cnt", ret_cnt, 2'd1);
        drive('0, '0, 2'b00);
        mready = 1'b1;
        #1;
        check("part_head", maddr, 32'h300);
        step();
        check("part_pop_count", sq_count, 3'd3);
        mready = 1'b0;
        drive(ns(5'd3, 1'b1), st(32'h314, 32'hB5), 2'b11);
        check("part_ready_sn", ready, 2'b11);
        step();
        check("part_upd_en", upd_en, 2'b10);
        check("part_upd_addr1", upd_addr[9:5], 5'd3);
        check("part_count_wrap", sq_count, 3'd4);
        drive('0, '0, 2'b00);
        mready = 1'b1;
        check("wrap_addr0", maddr, 32'h304);
        step();
        check("wrap_addr1", maddr, 32'h308);
        step();
        check("wrap_addr2", maddr, 32'h30C);
        step();
        check("wrap_addr3", maddr, 32'h314);
        check("wrap_data3", mdata, 32'hB5);
        step();
        check("wrap_empty", sq_empty, 1'b1);

        // Drain order with toggling mem ready, concurrent enqueue
        exp_a = 32'h100;
        nk    = 0;
        for (int c = 0; c < 40 && exp_a != 32'h118; c++) begin
            logic [IW-1:0] l0;
            logic [IW-1:0] l1;
            logic [1:0]    v;
            mready = (c % 2 == 0);
            l0 = '0;
            l1 = '0;
            v  = 2'b00;
            if (nk < 6) begin
                l0 = st(32'h100 + 32'(4 * nk), 32'hD000 + 32'(nk));
                v[0] = 1'b1;
            end
            if (nk + 1 < 6) begin
                l1 = st(32'h100 + 32'(4 * (nk + 1)), 32'hD000 + 32'(nk + 1));
                v[1] = 1'b1;
            end
            drive(l1, l0, v);
            if (mvalid) begin
                check("drain_addr", maddr, exp_a);
                check("drain_data", mdata, 32'hD000 + ((exp_a - 32'h100) >> 2));
                if (mready) exp_a = exp_a + 32'd4;
            end
            nk = nk + int'(ready[0]) + int'(ready[1]);
            step();
        end
        check("drain_all", exp_a, 32'h118);
        check("drain_enq_all", nk, 6);
        check("drain_empty", sq_empty, 1'b1);

        // Blocking: invalid lane0 blocks valid non-store lane1
        mready = 1'b0;
        drive(ns(5'd9, 1'b1), '0, 2'b10);
        check("block_ready", ready, 2'b00);
        step();
        check("block_upd_en", upd_en, 2'b00);
        check("block_ret_cnt", ret_cnt, 2'd0);

        // Reset mid-operation with 3 stores queued
        drive(st(32'h404, 32'hC1), st(32'h400, 32'hC0), 2'b11);
        step();
        drive('0, st(32'h408, 32'hC2), 2'b01);
        step();
        check("pre_rst_count", sq_count, 3'd3);
        rst = 1'b1;
        drive(ns(5'd2, 1'b1), ns(5'd1, 1'b1), 2'b11);
        step();
        check("post_rst_count", sq_count, 3'd0);
        check("post_rst_mvalid", mvalid, 1'b0);
        check("post_rst_upd_en", upd_en, 2'b00);
        check("post_rst_ret_cnt", ret_cnt, 2'd0);
        rst = 1'b0;
        drive('0, '0, 2'b00);
        step();
        check("post_rst_empty", sq_empty, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
